// File: rtl/vga_sync_gen.sv
// Raster timing generator for a VGA display: pixel-rate divider, beam counters,
// registered sync/blanking output stage and a per-frame tick for game logic.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] rgbIn,
    output logic [9:0] horCnt,
    output logic [9:0] verCnt,
    output logic       pixTick,
    output logic       frameTick,
    output logic       hSync,
    output logic       vSync,
    output logic       videoOn,
    output logic [5:0] rgbOut
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = 4;

    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCnt_q, divCnt_d;
    logic [9:0]    horCnt_q, horCnt_d;
    logic [9:0]    verCnt_q, verCnt_d;
    logic          hSync_q, hSync_d;
    logic          vSync_q, vSync_d;
    logic          videoOn_q, videoOn_d;
    logic [5:0]    rgbOut_q, rgbOut_d;
    logic          tick;
    logic          visible;

    // Decoded from the register, so with CLK_DIV=1 it stays high even in reset.
    assign tick    = (divCnt_q == DIV_LAST);
    assign visible = (horCnt_q < H_VIS) && (verCnt_q < V_VIS);

    always_comb begin
        divCnt_d  = tick ? '0 : divCnt_q + 1'b1;
        horCnt_d  = horCnt_q;
        verCnt_d  = verCnt_q;
        hSync_d   = hSync_q;
        vSync_d   = vSync_q;
        videoOn_d = videoOn_q;
        rgbOut_d  = rgbOut_q;
        if (tick) begin
            if (horCnt_q == H_LAST) begin
                horCnt_d = '0;
                verCnt_d = (verCnt_q == V_LAST) ? '0 : verCnt_q + 1'b1;
            end else begin
                horCnt_d = horCnt_q + 1'b1;
            end
            // Output stage samples the pre-increment coordinates: one pixel of lag.
            hSync_d   = !((horCnt_q >= HS_START) && (horCnt_q <= HS_END));
            vSync_d   = !((verCnt_q >= VS_START) && (verCnt_q <= VS_END));
            videoOn_d = visible;
            rgbOut_d  = visible ? rgbIn : 6'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt_q  <= '0;
            horCnt_q  <= '0;
            verCnt_q  <= '0;
            hSync_q   <= 1'b1;
            vSync_q   <= 1'b1;
            videoOn_q <= 1'b0;
            rgbOut_q  <= '0;
        end else begin
            divCnt_q  <= divCnt_d;
            horCnt_q  <= horCnt_d;
            verCnt_q  <= verCnt_d;
            hSync_q   <= hSync_d;
            vSync_q   <= vSync_d;
            videoOn_q <= videoOn_d;
            rgbOut_q  <= rgbOut_d;
        end
    end

    assign horCnt    = horCnt_q;
    assign verCnt    = verCnt_q;
    assign pixTick   = tick;
    assign frameTick = tick && (horCnt_q == H_LAST) && (verCnt_q == V_LAST);
    assign hSync     = hSync_q;
    assign vSync     = vSync_q;
    assign videoOn   = videoOn_q;
    assign rgbOut    = rgbOut_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken raster (30x17 pixels, CLK_DIV=4)
// so whole frames fit in a short run; a CLK_DIV=1 instance covers the tied-high tick.
module tb_vga_sync_gen;
    // Raster: H 16+4+6+4=30, V 10+2+2+3=17, frame = 30*17*4 = 2040 clks.
    // hSync low for columns [20,25], vSync low for lines [12,13].
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] rgbIn = 6'h3F;
    logic [9:0] horCnt, verCnt;
    logic       pixTick, frameTick, hSync, vSync, videoOn;
    logic [5:0] rgbOut;
    logic [9:0] horCnt1, verCnt1;
    logic       pixTick1, frameTick1, hSync1, vSync1, videoOn1;
    logic [5:0] rgbOut1;

    int errs = 0;
    int checks = 0;
    int cyc;
    bit mon_on = 1'b0;
    int ft_cnt = 0, ft_first = -1, ft_second = -1;
    int vs_low = 0, vis_col = 0, blank_col = 0, vid_cnt = 0;
    int max_hor = 0, max_ver = 0;

    vga_sync_gen #(
        .CLK_DIV(4), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut (
        .clk(clk), .reset(rst), .rgbIn(rgbIn), .horCnt(horCnt), .verCnt(verCnt),
        .pixTick(pixTick), .frameTick(frameTick), .hSync(hSync), .vSync(vSync),
        .videoOn(videoOn), .rgbOut(rgbOut)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut1 (
        .clk(clk), .reset(rst), .rgbIn(rgbIn), .horCnt(horCnt1), .verCnt(verCnt1),
        .pixTick(pixTick1), .frameTick(frameTick1), .hSync(hSync1), .vSync(vSync1),
        .videoOn(videoOn1), .rgbOut(rgbOut1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // Observation window covers the first two frames after power-up release.
    always @(negedge clk) begin
        if (mon_on && !rst && cyc <= 4100) begin
            if (frameTick) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = cyc;
                else if (ft_second < 0) ft_second = cyc;
            end
            if (cyc <= 2040) begin
                if (!vSync) vs_low++;
                if (videoOn) vid_cnt++;
                if (videoOn && rgbOut != 0) vis_col++;
                if (!videoOn && rgbOut != 0) blank_col++;
            end
            if (int'(horCnt) > max_hor) max_hor = int'(horCnt);
            if (int'(verCnt) > max_ver) max_ver = int'(verCnt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_to(input int t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) chk("run_to_timeout", cyc, t);
    endtask

    task automatic check_reset_state(input string p);
        chk({p, "_hor"}, horCnt, 0);
        chk({p, "_ver"}, verCnt, 0);
        chk({p, "_pix"}, pixTick, 0);
        chk({p, "_frame"}, frameTick, 0);
        chk({p, "_hs"}, hSync, 1);
        chk({p, "_vs"}, vSync, 1);
        chk({p, "_von"}, videoOn, 0);
        chk({p, "_rgb"}, rgbOut, 0);
        chk({p, "_pix_div1"}, pixTick1, 1);
    endtask

    task automatic check_startup(input string p);
        run_to(3);
        chk({p, "_pix_c3"}, pixTick, 1);
        chk({p, "_hor_c3"}, horCnt, 0);
        chk({p, "_rgb_c3"}, rgbOut, 0);
        run_to(4);
        chk({p, "_hor_c4"}, horCnt, 1);
        chk({p, "_pix_c4"}, pixTick, 0);
        chk({p, "_von_c4"}, videoOn, 1);
        chk({p, "_rgb_c4"}, rgbOut, 6'h3F);
        chk({p, "_pix_div1"}, pixTick1, 1);
    endtask

    initial begin
        repeat (10) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        mon_on = 1'b1;
        check_startup("up");

        // Column 15 is last visible, column 16 first blank (captured one pixel later).
        run_to(67);  chk("rgb_col15", rgbOut, 6'h3F);
        run_to(68);  chk("rgb_col16", rgbOut, 0);
        chk("von_col16", videoOn, 0);
        run_to(83);  chk("hs_before", hSync, 1);
        run_to(84);  chk("hs_fall", hSync, 0);
        run_to(107); chk("hs_last_low", hSync, 0);
        run_to(108); chk("hs_rise", hSync, 1);
        run_to(116); chk("hor_29", horCnt, 29);
        run_to(120); chk("wrap_hor", horCnt, 0);
        chk("wrap_ver", verCnt, 1);

        // Pixel (0,9) is captured on edge 1084; present a distinct colour for it.
        run_to(1082); rgbIn = 6'h2A;
        run_to(1084); chk("rgb_line9", rgbOut, 6'h2A);
        rgbIn = 6'h3F;
        run_to(1204); chk("rgb_line10", rgbOut, 0);
        chk("von_line10", videoOn, 0);

        run_to(2039); chk("ft_high", frameTick, 1);
        chk("ft_hor", horCnt, 29);
        chk("ft_ver", verCnt, 16);
        run_to(2040); chk("ft_low", frameTick, 0);
        chk("frame_hor", horCnt, 0);
        chk("frame_ver", verCnt, 0);

        run_to(4100);
        chk("ft_pulses", ft_cnt, 2);
        chk("ft_first", ft_first, 2039);
        chk("ft_period", ft_second - ft_first, 2040);
        chk("vs_low_clks", vs_low, 240);
        chk("von_clks", vid_cnt, 640);
        chk("vis_colour_clks", vis_col, 640);
        chk("blank_colour_clks", blank_col, 0);
        chk("max_hor", max_hor, 29);
        chk("max_ver", max_ver, 16);

        // Mid-frame reset at (10,5) of the third frame.
        mon_on = 1'b0;
        run_to(4080 + 640);
        chk("mid_hor", horCnt, 10);
        chk("mid_ver", verCnt, 5);
        chk("mid_von", videoOn, 1);
        rst = 1'b1;
        #1;
        check_reset_state("mid");
        repeat (3) @(negedge clk);
        check_reset_state("mid_hold");
        rst = 1'b0;
        check_startup("re");
        run_to(120); chk("re_wrap_hor", horCnt, 0);
        chk("re_wrap_ver", verCnt, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
